fibonacci_gen: RTL
==================

// Module: fibonacci_gen
// PURPOSE
//  Producer stage upstream of the clock-domain-crossing buffer. Generates the 16-bit
//  Fibonacci sequence F0..Fn in the fast clk_1 domain, presenting one term per
//  accepted cycle on data_1/data_1_en. Honours buffer_full back-pressure so no term
//  is lost or duplicated. Stops cleanly on the last term representable in WIDTH bits.
// PARAMETERS
//  WIDTH     16  data width of emitted terms; also the overflow limit
//  GAP       0   idle cycles inserted after each emitted term (0 = back-to-back)
//  IDX_W     5   width of term_idx; must satisfy 2**IDX_W > number of representable terms
// PORTS
//  clk_1        in   1      producer clock (fast domain); all logic on its rising edge
//  rst          in   1      reset, asynchronous, active-low
//  start        in   1      1-cycle request to begin or restart the sequence
//  stop         in   1      1-cycle request to abort the sequence
//  buffer_full  in   1      back-pressure from the downstream buffer; 1 = do not emit
//  data_1_en    out  1      1 for exactly one cycle per emitted term
//  data_1       out  WIDTH  emitted term; holds its last value while data_1_en = 0
//  term_idx     out  IDX_W  index n of the term currently on data_1 (F_n)
//  busy         out  1      1 in RUN or GAP
//  done         out  1      1 in DONE (sequence exhausted)
// BEHAVIOUR
//  - Reset (rst = 0, async): state IDLE; a = 0, b = 1, cb = 0, gap counter = 0.
//    All outputs 0: data_1, data_1_en, term_idx, busy, done.
//  - All outputs are registered. Internal registers: a (next term to emit), b, cb.
//    cb = 1 marks b as invalid because a+b carried out of WIDTH bits.
//  - States and transitions:
//    - IDLE: start = 1 and stop = 0 -> RUN. Otherwise stay. stop wins over start.
//    - RUN: stop = 1 -> IDLE and reseed. Otherwise, at each edge with buffer_full = 0,
//      emit: data_1 <= a, data_1_en <= 1, term_idx <= index of a.
//      Update a <= b, b <= (a+b)[WIDTH-1:0], cb <= carry of a+b.
//      If cb was already 1 at the emit, this is the last term -> DONE.
//      Otherwise -> GAP if GAP > 0, else stay in RUN.
//      With buffer_full = 1: data_1_en <= 0; a, b and cb hold; no term is skipped.
//    - GAP: data_1_en = 0. Count GAP cycles, then -> RUN. buffer_full is ignored here.
//      stop = 1 -> IDLE.
//    - DONE: data_1_en = 0; done = 1; data_1 and term_idx hold the last term.
//      start = 1 -> reseed and go to RUN. stop = 1 -> IDLE.
//  - Reseed (stop, restart, or reset): a = 0, b = 1, cb = 0, term_idx = 0.
//    data_1 keeps its last value, except on reset where it is cleared.
//  - Timing: start sampled at edge N gives RUN after N. The first term is emitted at
//    edge N+1 if buffer_full = 0 at that edge. done rises on the same edge as the last
//    data_1_en pulse.
//  - start during RUN or GAP is ignored. Asserting rst mid-run aborts immediately; the
//    partial sequence is not resumed.
//  - WIDTH = 16 gives 25 terms: F0 = 0 through F24 = 46368. F25 = 75025 overflows.
// TESTING
//  1. Reset, pulse start, buffer_full = 0, GAP = 0 -> data_1_en high 25 consecutive
//     cycles with data_1 = 0,1,1,2,3,5,...,28657,46368. term_idx goes 0..24.
//     done = 1 with the last term; busy = 0 afterwards.
//  2. As 1, but hold buffer_full = 1 for 3 cycles after the term 3 is emitted ->
//     data_1_en low for 3 cycles, then the next term is 5. No duplicate or missing term.
//  3. stop pulse after term 8 is emitted -> IDLE next cycle, busy = 0, data_1 holds 8.
//     A new start restarts at 0 with term_idx = 0.
//  4. From DONE, pulse start -> sequence restarts at 0 and done deasserts.
//     A second start pulse mid-run is ignored and does not change the sequence.
//  5. Drive rst = 0 asynchronously mid-cycle during RUN -> all outputs 0 immediately.
//     Release rst and pulse start -> sequence begins at 0.
//  6. GAP = 2 -> data_1_en pulses every 3rd cycle, values unchanged from test 1.
//     start and stop in the same cycle while in IDLE -> remains IDLE.

Source files
------------

// File: rtl/fibonacci_gen.sv
// Fibonacci term producer with back-pressure, optional inter-term gap and
// clean termination on the last term that fits in WIDTH bits.
module fibonacci_gen #(
   parameter int WIDTH = 16,
   parameter int GAP   = 0,
   parameter int IDX_W = 5
) (
   input  logic             clk_1,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             buffer_full,
   output logic             data_1_en,
   output logic [WIDTH-1:0] data_1,
   output logic [IDX_W-1:0] term_idx,
   output logic             busy,
   output logic             done
);

   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_GAP,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               cb_q, cb_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               en_q, en_d;
   logic [IDX_W-1:0]   term_idx_q, term_idx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH:0]     sum;
   logic               reseed;

   assign sum = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      cb_d       = cb_q;
      idx_d      = idx_q;
      gap_cnt_d  = gap_cnt_q;
      data_d     = data_q;
      en_d       = 1'b0;
      term_idx_d = term_idx_q;
      reseed     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               state_d = S_RUN;
               reseed  = 1'b1;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_d = S_IDLE;
               reseed  = 1'b1;
            end else if (!buffer_full) begin
               en_d       = 1'b1;
               data_d     = a_q;
               term_idx_d = idx_q;
               a_d        = b_q;
               b_d        = sum[WIDTH-1:0];
               cb_d       = sum[WIDTH];
               idx_d      = idx_q + 1'b1;
               // cb already set means b overflowed, so a is the final term
               if (cb_q) begin
                  state_d = S_DONE;
               end else if (GAP > 0) begin
                  state_d   = S_GAP;
                  gap_cnt_d = '0;
               end
            end
         end
         S_GAP: begin
            if (stop) begin
               state_d = S_IDLE;
               reseed  = 1'b1;
            end else if (gap_cnt_q == GAP_LAST) begin
               state_d = S_RUN;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (stop) begin
               state_d = S_IDLE;
               reseed  = 1'b1;
            end else if (start) begin
               state_d = S_RUN;
               reseed  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            reseed  = 1'b1;
         end
      endcase

      // data_1 deliberately survives a reseed; only reset clears it
      if (reseed) begin
         a_d        = '0;
         b_d        = WIDTH'(1);
         cb_d       = 1'b0;
         idx_d      = '0;
         gap_cnt_d  = '0;
         term_idx_d = '0;
      end

      busy_d = (state_d == S_RUN) || (state_d == S_GAP);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= WIDTH'(1);
         cb_q       <= 1'b0;
         idx_q      <= '0;
         gap_cnt_q  <= '0;
         data_q     <= '0;
         en_q       <= 1'b0;
         term_idx_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cb_q       <= cb_d;
         idx_q      <= idx_d;
         gap_cnt_q  <= gap_cnt_d;
         data_q     <= data_d;
         en_q       <= en_d;
         term_idx_q <= term_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign data_1_en = en_q;
   assign data_1    = data_q;
   assign term_idx  = term_idx_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
